// File: rtl/timer_pkg.sv
// Shared types and helpers for the mm:ss countdown timer.
package timer_pkg;

   localparam int DIGIT_W = 4;
   localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;
   localparam logic [DIGIT_W-1:0] DIGIT_MAX    = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_PAUSED,
      ST_DONE
   } state_e;

   typedef struct packed {
      logic [DIGIT_W-1:0] min_tens;
      logic [DIGIT_W-1:0] min_ones;
      logic [DIGIT_W-1:0] sec_tens;
      logic [DIGIT_W-1:0] sec_ones;
   } bcd_time_t;

   function automatic logic [DIGIT_W-1:0] sat_digit(input logic [DIGIT_W-1:0] d,
                                                    input logic [DIGIT_W-1:0] max);
      return (d > max) ? max : d;
   endfunction

   // Out-of-range BCD digits saturate instead of being rejected.
   function automatic bcd_time_t clamp_time(input logic [7:0] mn, input logic [7:0] sc);
      bcd_time_t t;
      t.min_tens = sat_digit(mn[7:4], DIGIT_MAX);
      t.min_ones = sat_digit(mn[3:0], DIGIT_MAX);
      t.sec_tens = sat_digit(sc[7:4], SEC_TENS_MAX);
      t.sec_ones = sat_digit(sc[3:0], DIGIT_MAX);
      return t;
   endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the down-counter; wraps to max_i and borrows from the next digit at zero.
module bcd_down_digit
   import timer_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit_i,
   input  logic [DIGIT_W-1:0] max_i,
   input  logic               borrow_i,
   output logic [DIGIT_W-1:0] digit_o,
   output logic               borrow_o
);

   logic is_zero;

   assign is_zero  = (digit_i == '0);
   assign borrow_o = borrow_i & is_zero;

   always_comb begin
      digit_o = digit_i;
      if (borrow_i) digit_o = is_zero ? max_i : digit_i - 1'b1;
   end

endmodule

// File: rtl/countdown_timer.sv
// mm:ss BCD countdown: edge-detects the 1 Hz level, runs the IDLE/RUN/PAUSED/DONE
// control and drives registered digits and status to the display scanner.
module countdown_timer
   import timer_pkg::*;
#(
   parameter logic [7:0] DEFAULT_MIN = 8'h02,
   parameter logic [7:0] DEFAULT_SEC = 8'h00
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         sec_lvl,
   input  logic         start,
   input  logic         pause,
   input  logic         load,
   input  logic [7:0]   load_min,
   input  logic [7:0]   load_sec,
   output logic [3:0]   min_tens,
   output logic [3:0]   min_ones,
   output logic [3:0]   sec_tens,
   output logic [3:0]   sec_ones,
   output logic         running,
   output logic         done,
   output logic         done_pulse,
   output logic         blank
);

   localparam int NUM_DIG = 4;
   // Digit order [0]=sec_ones .. [3]=min_tens, matching the packed time struct.
   localparam logic [NUM_DIG-1:0][DIGIT_W-1:0] DIG_MAX = {DIGIT_MAX, DIGIT_MAX, SEC_TENS_MAX, DIGIT_MAX};

   state_e    state_q, state_d;
   bcd_time_t time_q, time_d, dec_time;
   logic      sec_prev_q;
   logic      blank_q, blank_d;
   logic      pulse_q, pulse_d;
   logic      running_q, done_q;
   logic      tick, time_zero;

   logic [NUM_DIG-1:0][DIGIT_W-1:0] cur_dig, dec_dig;
   logic [NUM_DIG:0]                borrow;

   assign tick      = sec_lvl & ~sec_prev_q;
   assign time_zero = (time_q == '0);

   assign cur_dig   = time_q;
   assign borrow[0] = 1'b1;
   assign dec_time  = dec_dig;

   genvar g;
   generate
      for (g = 0; g < NUM_DIG; g++) begin : g_dig
         bcd_down_digit u_dig (
            .digit_i  (cur_dig[g]),
            .max_i    (DIG_MAX[g]),
            .borrow_i (borrow[g]),
            .digit_o  (dec_dig[g]),
            .borrow_o (borrow[g+1])
         );
      end
   endgenerate

   // A command that does nothing in the current state never masks a lower-priority one.
   always_comb begin
      state_d = state_q;
      time_d  = time_q;
      blank_d = blank_q;
      pulse_d = 1'b0;
      if (load) begin
         state_d = ST_IDLE;
         time_d  = clamp_time(load_min, load_sec);
         blank_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  if (time_zero) begin
                     state_d = ST_DONE;
                     pulse_d = 1'b1;
                  end else begin
                     state_d = ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (pause) begin
                  state_d = ST_PAUSED;
               end else if (tick && !time_zero) begin
                  time_d = dec_time;
                  if (dec_time == '0) begin
                     state_d = ST_DONE;
                     pulse_d = 1'b1;
                  end
               end
            end
            ST_PAUSED: begin
               if (start) state_d = ST_RUN;
            end
            ST_DONE: begin
               time_d = '0;
               if (tick) blank_d = ~blank_q;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         time_q     <= {DEFAULT_MIN, DEFAULT_SEC};
         sec_prev_q <= 1'b1;
         blank_q    <= 1'b0;
         pulse_q    <= 1'b0;
         running_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         time_q     <= time_d;
         sec_prev_q <= sec_lvl;
         blank_q    <= blank_d;
         pulse_q    <= pulse_d;
         running_q  <= (state_d == ST_RUN);
         done_q     <= (state_d == ST_DONE);
      end
   end

   assign min_tens   = time_q.min_tens;
   assign min_ones   = time_q.min_ones;
   assign sec_tens   = time_q.sec_tens;
   assign sec_ones   = time_q.sec_ones;
   assign running    = running_q;
   assign done       = done_q;
   assign done_pulse = pulse_q;
   assign blank      = blank_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: seconds-count reference model checked every cycle,
// directed scenarios with literal expectations, then randomized commands.
module tb_countdown_timer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sec_lvl = 1'b0;
   logic       start = 1'b0, pause = 1'b0, load = 1'b0;
   logic [7:0] load_min = 8'h00, load_sec = 8'h00;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   logic       running, done, done_pulse, blank;

   int errors = 0;
   int checks = 0;
   bit check_en = 1'b0;

   countdown_timer #(.DEFAULT_MIN(8'h02), .DEFAULT_SEC(8'h00)) dut (
      .clk(clk), .rst(rst), .sec_lvl(sec_lvl),
      .start(start), .pause(pause), .load(load),
      .load_min(load_min), .load_sec(load_sec),
      .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
      .running(running), .done(done), .done_pulse(done_pulse), .blank(blank)
   );

   always #5 clk = ~clk;

   wire [15:0] dig = {min_tens, min_ones, sec_tens, sec_ones};

   // Reference model: the time is a plain count of seconds.
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;
   int m_st, m_total;
   bit m_prev, m_blank, m_pulse;

   function automatic int sat(input int d, input int max);
      return (d > max) ? max : d;
   endfunction

   function automatic int load_secs(input logic [7:0] mn, input logic [7:0] sc);
      int mt, mo, st, so;
      mt = sat(int'(mn[7:4]), 9);
      mo = sat(int'(mn[3:0]), 9);
      st = sat(int'(sc[7:4]), 5);
      so = sat(int'(sc[3:0]), 9);
      return (mt * 10 + mo) * 60 + st * 10 + so;
   endfunction

   function automatic logic [15:0] to_bcd(input int total);
      int m, s;
      m = total / 60;
      s = total % 60;
      return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_st = M_IDLE; m_total = 120; m_prev = 1'b1; m_blank = 1'b0; m_pulse = 1'b0;
      end else begin
         bit tk;
         tk = sec_lvl && !m_prev;
         m_prev = sec_lvl;
         m_pulse = 1'b0;
         if (load) begin
            m_total = load_secs(load_min, load_sec);
            m_st = M_IDLE;
            m_blank = 1'b0;
         end else begin
            case (m_st)
               M_IDLE:
                  if (start) begin
                     if (m_total == 0) begin m_st = M_DONE; m_pulse = 1'b1; end
                     else m_st = M_RUN;
                  end
               M_RUN:
                  if (pause) m_st = M_PAUSED;
                  else if (tk && m_total > 0) begin
                     m_total = m_total - 1;
                     if (m_total == 0) begin m_st = M_DONE; m_pulse = 1'b1; end
                  end
               M_PAUSED: if (start) m_st = M_RUN;
               default:  if (tk) m_blank = !m_blank;
            endcase
         end
      end
   end

   // One whole-output comparison per cycle against the model.
   always @(negedge clk) begin
      if (check_en) begin
         logic [19:0] got, exp;
         got = {dig, running, done, done_pulse, blank};
         exp = {to_bcd(m_total), m_st == M_RUN, m_st == M_DONE, m_pulse, m_blank};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL model_cmp t=%0t got=%h exp=%h (digits,run,done,pulse,blank)", $time, got, exp);
         end
      end
   end

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_load(input logic [7:0] mn, input logic [7:0] sc);
      load_min = mn; load_sec = sc; load = 1'b1;
      cycle();
      load = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      cycle();
      start = 1'b0;
   endtask

   task automatic tick();
      sec_lvl = 1'b1;
      cycle();
      sec_lvl = 1'b0;
      cycle();
   endtask

   initial begin
      @(negedge clk);
      cycle();
      check_en = 1'b1;
      chk("reset_digits", dig, 16'h0200);
      chk("reset_flags", {12'h0, running, done, done_pulse, blank}, 16'h0);
      rst = 1'b0;

      // default value counting
      do_start();
      chk("start_running", {15'h0, running}, 16'h1);
      repeat (3) tick();
      chk("three_ticks", dig, 16'h0157);

      // count to zero, then blink
      do_load(8'h00, 8'h02);
      do_start();
      tick();
      sec_lvl = 1'b1; cycle();
      chk("done_entry", {dig, done_pulse, done} == {16'h0000, 2'b11} ? 16'h1 : 16'h0, 16'h1);
      sec_lvl = 1'b0; cycle();
      chk("done_pulse_one_cycle", {15'h0, done_pulse}, 16'h0);
      for (int i = 0; i < 3; i++) begin
         sec_lvl = 1'b1; cycle();
         chk("blank_toggle", {15'h0, blank}, (i % 2 == 0) ? 16'h1 : 16'h0);
         sec_lvl = 1'b0; cycle();
      end
      chk("done_hold", dig, 16'h0000);

      // full borrow and clamping
      do_load(8'h10, 8'h00);
      do_start();
      tick();
      chk("borrow_chain", dig, 16'h0959);
      do_load(8'hF7, 8'h7C);
      chk("clamp_f7_7c", dig, 16'h9759);
      do_load(8'hFF, 8'hFF);
      chk("clamp_max", dig, 16'h9959);
      do_start();
      tick();
      chk("max_dec", dig, 16'h9958);

      // pause wins over a simultaneous tick
      do_load(8'h00, 8'h10);
      do_start();
      tick();
      chk("pre_pause", dig, 16'h0009);
      pause = 1'b1; sec_lvl = 1'b1; cycle();
      pause = 1'b0;
      chk("pause_tick_same", {dig[15:1], running}, {16'h0009} & 16'hFFFE);
      sec_lvl = 1'b0; cycle();
      repeat (5) tick();
      chk("paused_hold", dig, 16'h0009);
      do_start();
      tick();
      chk("resume_dec", dig, 16'h0008);

      // level already high across reset release
      sec_lvl = 1'b1; rst = 1'b1; cycle();
      rst = 1'b0;
      do_start();
      chk("lvl_high_no_dec", dig, 16'h0200);
      cycle();
      chk("lvl_high_hold", dig, 16'h0200);
      sec_lvl = 1'b0; cycle();
      sec_lvl = 1'b1; cycle();
      chk("lvl_next_rise", dig, 16'h0159);
      sec_lvl = 1'b0; cycle();

      // zero start, ignored start in DONE, load exits
      do_load(8'h00, 8'h00);
      do_start();
      chk("zero_start_done", {14'h0, done, done_pulse}, 16'h3);
      do_start();
      chk("done_start_ignored", {14'h0, done, done_pulse}, 16'h2);
      tick();
      chk("done_blank_set", {15'h0, blank}, 16'h1);
      do_load(8'h00, 8'h05);
      chk("reload_exit", {dig[11:0], running, done, blank, 1'b0}, {12'h005, 4'h0});

      // randomized commands
      for (int i = 0; i < 4000; i++) begin
         rst   = ($urandom % 300) == 0;
         load  = ($urandom % 40) == 0;
         start = ($urandom % 8) == 0;
         pause = ($urandom % 12) == 0;
         if (($urandom % 3) == 0) sec_lvl = ~sec_lvl;
         load_min = (($urandom % 3) == 0) ? 8'($urandom) : 8'h00;
         load_sec = (($urandom % 2) == 0) ? 8'($urandom % 8) : 8'($urandom);
         cycle();
      end
      rst = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
      cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
